uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo_if.sv | 29 ++
 rtl/uart_rx_fifo.sv | 79 +++++++
 tb/tb_uart_rx_fifo.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Bus between the UART receiver / consumer side and the receive FIFO.
// The master drives the write/read strobes, the slave (the FIFO) returns
// the head word and the occupancy flags.
interface uart_rx_fifo_if #(
  parameter int data_bits = 8,
  parameter int addr_bits = 4
) ();

  logic                 wr;
  logic [data_bits-1:0] w_data;
  logic                 rd;
  logic                 clr_overflow;
  logic [data_bits-1:0] r_data;
  logic                 empty;
  logic                 full;
  logic [addr_bits:0]   count;
  logic                 overflow;

  modport master (
    output wr, w_data, rd, clr_overflow,
    input  r_data, empty, full, count, overflow
  );

  modport slave (
    input  wr, w_data, rd, clr_overflow,
    output r_data, empty, full, count, overflow
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO placed behind a UART receiver. Words arrive on the write
// strobe, the consumer sees the oldest word fall through on r_data and pops
// it with rd. A word that arrives while the FIFO is full and nobody is
// reading is dropped and recorded in the sticky overflow flag.
module uart_rx_fifo #(
  parameter int data_bits = 8,
  parameter int addr_bits = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  uart_rx_fifo_if.slave   bus
);

  localparam int Depth = 1 << addr_bits;
  localparam logic [addr_bits:0] PtrOne = 1;

  logic [data_bits-1:0] mem_q [Depth];
  logic [addr_bits:0]   wrPtr_q, wrPtr_d;
  logic [addr_bits:0]   rdPtr_q, rdPtr_d;
  logic                 overflow_q, overflow_d;

  logic emptyFlag;
  logic fullFlag;
  logic rdAccept;
  logic wrAccept;
  logic dropWord;

  // The extra pointer bit tells a full FIFO from an empty one when the
  // address bits coincide; flags depend only on registered pointers.
  assign emptyFlag = (wrPtr_q == rdPtr_q);
  assign fullFlag  = (wrPtr_q[addr_bits-1:0] == rdPtr_q[addr_bits-1:0]) &&
                     (wrPtr_q[addr_bits] != rdPtr_q[addr_bits]);

  // A pop frees a slot on the same edge, so a full FIFO can still take a
  // write when it is being read at the same time.
  assign rdAccept = bus.rd && !emptyFlag;
  assign wrAccept = bus.wr && (!fullFlag || rdAccept);
  assign dropWord = bus.wr && fullFlag && !bus.rd;

  assign bus.empty    = emptyFlag;
  assign bus.full     = fullFlag;
  assign bus.count    = wrPtr_q - rdPtr_q;
  assign bus.overflow = overflow_q;
  assign bus.r_data   = mem_q[rdPtr_q[addr_bits-1:0]];

  // Next pointer values and overflow flag; a new drop beats a clear.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    overflow_d = overflow_q;
    if (wrAccept) wrPtr_d = wrPtr_q + PtrOne;
    if (rdAccept) rdPtr_d = rdPtr_q + PtrOne;
    if (dropWord) begin
      overflow_d = 1'b1;
    end else if (bus.clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  // Pointer and flag registers; reset empties the FIFO immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array is deliberately left out of reset; stale words are
  // unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (wrAccept) mem_q[wrPtr_q[addr_bits-1:0]] <= bus.w_data;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random
// traffic, compared against a queue-based model of the FIFO behaviour.
module tb_uart_rx_fifo;

  logic clk;
  logic reset_n;

  int checks;
  int errors;

  logic [7:0] model[$];
  logic       modelOvf;

  uart_rx_fifo_if #(.data_bits(8), .addr_bits(4)) bus ();

  uart_rx_fifo #(.data_bits(8), .addr_bits(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare all DUT outputs with what the model says the FIFO holds.
  task automatic checkOutput(input string tag);
    logic [7:0] expCount;
    expCount = 8'(model.size());
    checkVal({tag, ".count"}, 8'(bus.count), expCount);
    checkVal({tag, ".empty"}, 8'(bus.empty), 8'(model.size() == 0));
    checkVal({tag, ".full"}, 8'(bus.full), 8'(model.size() == 16));
    checkVal({tag, ".overflow"}, 8'(bus.overflow), 8'(modelOvf));
    if (model.size() != 0) checkVal({tag, ".r_data"}, bus.r_data, model[0]);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, and
  // return 1 time unit after the edge with strobes released.
  task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r, input logic c);
    int sizeBefore;
    bus.wr = w;
    bus.w_data = d;
    bus.rd = r;
    bus.clr_overflow = c;
    @(posedge clk);
    sizeBefore = model.size();
    if (r && sizeBefore > 0) void'(model.pop_front());
    if (w && (sizeBefore < 16 || (r && sizeBefore > 0))) model.push_back(d);
    if (w && sizeBefore == 16 && !r) modelOvf = 1'b1;
    else if (c) modelOvf = 1'b0;
    #1;
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    bus.clr_overflow = 1'b0;
  endtask

  initial begin
    int writes;
    int cycles;
    logic w;
    logic r;
    checks = 0;
    errors = 0;
    modelOvf = 1'b0;
    bus.wr = 1'b0;
    bus.w_data = '0;
    bus.rd = 1'b0;
    bus.clr_overflow = 1'b0;

    // Reset state
    reset_n = 1'b0;
    #12;
    checkOutput("reset");

    // Single write after release shows on the next cycle
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    checkOutput("firstWrite");
    checkVal("firstWrite.data", bus.r_data, 8'hA5);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("firstPop");

    // Fill with 0x00..0x0F, then drain in order
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
    checkOutput("filled");
    checkVal("filled.full", 8'(bus.full), 8'h01);
    for (int i = 0; i < 16; i++) begin
      checkVal("drain.order", bus.r_data, 8'(i));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checkOutput("drained");

    // Overflow on full, clear, and set winning over clear
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
    checkOutput("overflowSet");
    checkVal("overflowSet.head", bus.r_data, 8'h30);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("overflowClr");
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1);
    checkOutput("setBeatsClr");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Simultaneous write and read while full
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
    checkOutput("fullRdWr");
    for (int i = 0; i < 16; i++) begin
      if (i == 15) checkVal("fullRdWr.last", bus.r_data, 8'h55);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checkOutput("fullRdWrDrained");

    // Read on empty is ignored; write+read on empty writes only
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("emptyRd");
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
    checkOutput("emptyRdWr");

    // 40 random writes interleaved with reads, staying below full
    writes = 0;
    cycles = 0;
    while (writes < 40 && cycles < 2000) begin
      w = (model.size() < 15) ? 1'($urandom_range(0, 1)) : 1'b0;
      r = 1'($urandom_range(0, 2) == 0);
      if (w) writes++;
      applyStimulus(w, 8'($urandom), r, 1'b0);
      checkOutput("interleave");
      cycles++;
    end
    checkVal("interleave.done", 8'(writes), 8'd40);

    // Unconstrained random traffic including overflow and clear
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 8'($urandom),
                    1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
      checkOutput("random");
    end

    // Asynchronous reset mid-stream, no edge needed
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    model.delete();
    modelOvf = 1'b0;
    #1;
    checkOutput("asyncReset");

    // First rising edge after release accepts a write
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
    checkOutput("postReset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
